// File: rtl/alu_writeback_pkg.sv
// Shared ALU parameters: op codes and architectural flag bit positions.
package alu_writeback_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_EQUAL  = 5'd4;
    localparam logic [4:0] OP_DIVIDE = 5'd5;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic op_is_legal(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR) || (op == OP_EQUAL) || (op == OP_DIVIDE);
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry in-order skid FIFO with 1-bit wrapping pointers.
module wb_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [1:0]       count_o,
    output logic             full_o,
    output logic             empty_o
);
    import alu_writeback_pkg::*;

    logic [WIDTH-1:0] mem_q [2];
    logic             wptr_q, rptr_q;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == 2'(DEPTH));
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 2'd1;
        else if (do_pop && !do_push)
            count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) wptr_q <= ~wptr_q;
            if (do_pop)  rptr_q <= ~rptr_q;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: derives N/Z/C/V, buffers results across register-file stalls,
// and retires them in order as register writes plus a flags update.
module alu_writeback #(
    parameter int DATA_W  = 36,
    parameter int RADDR_W = 4,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_result,
    input  logic               in_cout,
    input  logic [4:0]         in_op,
    input  logic               in_a_msb,
    input  logic               in_b_msb,
    input  logic               in_b_zero,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_wen,
    input  logic               rf_stall,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [3:0]         flags,
    output logic               err,
    output logic               busy
);
    import alu_writeback_pkg::*;

    // Entry layout: {err, upd_flags, wen, rd, data, flags}
    localparam int ENTRY_W = 3 + RADDR_W + DATA_W + 4;

    function automatic logic [3:0] derive_flags(
        input logic [4:0]        op,
        input logic [DATA_W-1:0] result,
        input logic              cout,
        input logic              a_msb,
        input logic              b_msb,
        input logic              b_zero
    );
        logic signed [DATA_W-1:0] res_s;
        logic [3:0]               f;
        res_s     = $signed(result);
        f         = 4'b0000;
        f[FLAG_N] = (res_s < 0);
        f[FLAG_Z] = (result == '0);
        case (op)
            OP_ADD: begin
                f[FLAG_C] = cout;
                f[FLAG_V] = (a_msb == b_msb) && (f[FLAG_N] != a_msb);
            end
            OP_SUB: begin
                f[FLAG_C] = cout;
                f[FLAG_V] = (a_msb != b_msb) && (f[FLAG_N] != a_msb);
            end
            OP_DIVIDE: if (b_zero) f = 4'b0001;
            default: ;
        endcase
        return f;
    endfunction

    logic               legal, div_zero;
    logic               ent_err, ent_upd, ent_wen;
    logic [3:0]         ent_flags;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic [1:0]         fifo_count;
    logic               fifo_full, fifo_empty;
    logic               push, retire;

    logic               head_err, head_upd, head_wen;
    logic [RADDR_W-1:0] head_rd;
    logic [DATA_W-1:0]  head_data;
    logic [3:0]         head_flags;

    logic [3:0]         flags_q, flags_d;
    logic               err_q, err_d;

    assign legal     = op_is_legal(in_op);
    assign div_zero  = (in_op == OP_DIVIDE) && in_b_zero;
    assign ent_flags = derive_flags(in_op, in_result, in_cout, in_a_msb, in_b_msb, in_b_zero);
    assign ent_err   = !legal || div_zero;
    assign ent_upd   = legal;
    // r0 is hard-wired zero, so its writes are dropped while flags still update.
    assign ent_wen   = in_wen && legal && !div_zero && (in_rd != '0);

    assign push_entry = {ent_err, ent_upd, ent_wen, in_rd, in_result, ent_flags};

    assign in_ready = (fifo_count < 2'(DEPTH));
    assign push     = in_valid && !fifo_full;
    assign retire   = !fifo_empty && !rf_stall;

    wb_skid_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (retire),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_err, head_upd, head_wen, head_rd, head_data, head_flags} = head_entry;

    assign rf_we    = retire && head_wen;
    assign rf_waddr = fifo_empty ? '0 : head_rd;
    assign rf_wdata = fifo_empty ? '0 : head_data;
    assign busy     = !fifo_empty;

    always_comb begin
        flags_d = flags_q;
        err_d   = retire && head_err;
        if (retire && head_upd) flags_d = head_flags;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign flags = flags_q;
    assign err   = err_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: queue-based reference model plus hand-computed checks.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_result;
    logic        in_cout;
    logic [4:0]  in_op;
    logic        in_a_msb, in_b_msb, in_b_zero;
    logic [3:0]  in_rd;
    logic        in_wen;
    logic        rf_stall;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [35:0] rf_wdata;
    logic [3:0]  flags;
    logic        err;
    logic        busy;

    always #5 clk = ~clk;

    alu_writeback #(.DATA_W(36), .RADDR_W(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_cout   (in_cout),
        .in_op     (in_op),
        .in_a_msb  (in_a_msb),
        .in_b_msb  (in_b_msb),
        .in_b_zero (in_b_zero),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .flags     (flags),
        .err       (err),
        .busy      (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of pending retirements.
    typedef struct packed {
        logic        we;
        logic [3:0]  rd;
        logic [35:0] data;
        logic        upd;
        logic        er;
        logic [3:0]  fl;
    } ent_t;

    ent_t       mq[$];
    logic [3:0] m_flags = 4'b0;
    logic       m_err   = 1'b0;

    function automatic ent_t model_entry();
        ent_t e;
        bit   legal, dz, n, z, c, v;
        legal = in_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EQUAL, OP_DIVIDE};
        dz    = (in_op == OP_DIVIDE) && in_b_zero;
        n     = in_result[35];
        z     = (in_result == 36'd0);
        c     = (in_op == OP_ADD || in_op == OP_SUB) ? in_cout : 1'b0;
        v     = 1'b0;
        if (in_op == OP_ADD) v = (in_a_msb == in_b_msb) && (n != in_a_msb);
        if (in_op == OP_SUB) v = (in_a_msb != in_b_msb) && (n != in_a_msb);
        e.fl   = dz ? 4'b0001 : {n, z, c, v};
        e.upd  = legal;
        e.er   = !legal || dz;
        e.we   = legal && !dz && in_wen && (in_rd != 4'd0);
        e.rd   = in_rd;
        e.data = in_result;
        return e;
    endfunction

    always @(posedge clk) begin
        int   sz;
        bit   ret, acc;
        ent_t ne;
        if (!rst_n) begin
            mq.delete();
            m_flags = 4'b0;
            m_err   = 1'b0;
        end else begin
            sz  = mq.size();
            ret = (sz > 0) && !rf_stall;
            acc = in_valid && (sz < 2);
            ne  = model_entry();
            m_err = ret && mq[0].er;
            if (ret) begin
                if (mq[0].upd) m_flags = mq[0].fl;
                void'(mq.pop_front());
            end
            if (acc) mq.push_back(ne);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit ne_q;
            ne_q = mq.size() > 0;
            chk("in_ready", in_ready, mq.size() < 2);
            chk("busy", busy, ne_q);
            chk("rf_we", rf_we, ne_q && !rf_stall && mq[0].we);
            chk("rf_waddr", rf_waddr, ne_q ? mq[0].rd : 4'd0);
            chk("rf_wdata", rf_wdata, ne_q ? mq[0].data : 36'd0);
            chk("flags", flags, m_flags);
            chk("err", err, m_err);
        end
    end

    task automatic drive(input logic [4:0] op, input logic [35:0] res, input logic cout,
                         input logic a, input logic b, input logic bz,
                         input logic [3:0] rd, input logic wen);
        in_op = op; in_result = res; in_cout = cout;
        in_a_msb = a; in_b_msb = b; in_b_zero = bz;
        in_rd = rd; in_wen = wen; in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: got no accept, expected accept within 20 cycles");
    endtask

    task automatic send(input logic [4:0] op, input logic [35:0] res, input logic cout,
                        input logic a, input logic b, input logic bz,
                        input logic [3:0] rd, input logic wen);
        drive(op, res, cout, a, b, bz, rd, wen);
        wait_accept();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_cout = 1'b0; in_op = '0;
        in_a_msb = 1'b0; in_b_msb = 1'b0; in_b_zero = 1'b0; in_rd = '0; in_wen = 1'b0;
        rf_stall = 1'b0;
        @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_rf_we", rf_we, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ADD overflow into sign bit
        send(OP_ADD, 36'h8_0000_0000, 0, 0, 0, 0, 4'd3, 1);
        @(negedge clk);
        chk("add_we", rf_we, 1);
        chk("add_waddr", rf_waddr, 4'd3);
        chk("add_wdata", rf_wdata, 36'h8_0000_0000);
        @(posedge clk); #1;
        chk("add_flags", flags, 4'b1001);

        // SUB to zero, then SUB negative with carry
        send(OP_SUB, 36'h0, 0, 0, 0, 0, 4'd5, 1);
        @(negedge clk);
        chk("sub0_waddr", rf_waddr, 4'd5);
        chk("sub0_wdata", rf_wdata, 36'h0);
        @(posedge clk); #1;
        chk("sub0_flags", flags, 4'b0100);
        send(OP_SUB, 36'hF_FFFF_FFFF, 1, 0, 0, 0, 4'd6, 1);
        @(posedge clk); #1;
        chk("subn_flags", flags, 4'b1010);

        // Divide by zero
        send(OP_DIVIDE, 36'h123, 0, 0, 0, 1, 4'd2, 1);
        @(negedge clk);
        chk("div0_we", rf_we, 0);
        @(posedge clk); #1;
        chk("div0_flags", flags, 4'b0001);
        chk("div0_err", err, 1);
        @(posedge clk); #1;
        chk("div0_err_off", err, 0);

        // AND with stale carry targeting r0
        send(OP_AND, 36'h0, 1, 0, 0, 0, 4'd0, 1);
        @(negedge clk);
        chk("and_r0_we", rf_we, 0);
        @(posedge clk); #1;
        chk("and_flags", flags, 4'b0100);

        // Illegal op: flags held, err pulses
        send(5'd20, 36'h5, 1, 1, 0, 0, 4'd4, 1);
        @(posedge clk); #1;
        chk("ill_flags", flags, 4'b0100);
        chk("ill_err", err, 1);
        @(posedge clk); #1;
        chk("ill_err_off", err, 0);

        // Back-to-back throughput, including a legal divide
        send(OP_OR, 36'h7_0000_0001, 0, 1, 1, 0, 4'd1, 1);
        send(OP_EQUAL, 36'h1, 0, 0, 0, 0, 4'd12, 1);
        send(OP_DIVIDE, 36'h9, 1, 1, 0, 0, 4'd13, 1);
        send(OP_ADD, 36'h3, 1, 1, 1, 0, 4'd14, 0);
        repeat (3) @(posedge clk);
        #1;

        // Stall: two absorbed, third held until space opens
        rf_stall = 1'b1;
        send(OP_ADD, 36'h1, 0, 0, 0, 0, 4'd7, 1);
        send(OP_OR, 36'h2, 0, 0, 0, 0, 4'd8, 1);
        drive(OP_EQUAL, 36'h0, 0, 0, 0, 0, 4'd9, 1);
        @(negedge clk);
        chk("stall_ready", in_ready, 0);
        chk("stall_we", rf_we, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_ready2", in_ready, 0);
        @(posedge clk); #1;
        rf_stall = 1'b0;
        @(negedge clk);
        chk("rel_we0", rf_we, 1);
        chk("rel_addr0", rf_waddr, 4'd7);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_addr1", rf_waddr, 4'd8);
        chk("rel_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel_addr2", rf_waddr, 4'd9);
        chk("rel_we2", rf_we, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset flush with two buffered entries
        rf_stall = 1'b1;
        send(OP_ADD, 36'hA, 0, 0, 0, 0, 4'd10, 1);
        send(OP_SUB, 36'hB, 0, 0, 0, 0, 4'd11, 1);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_flags", flags, 4'b0000);
        rf_stall = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("flush_no_we", rf_we, 0);
        end
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
